lcd_onchip_memory_dp: RTL and testbench

//  Parametrised true dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) for the LCD subsystem.

---
 rtl/lcd_onchip_memory_dp_pkg.sv | 12 +
 rtl/lcd_mem_tdp_ram.sv | 47 ++++
 rtl/lcd_onchip_memory_dp.sv | 150 +++++++++++++++
 tb/tb_lcd_onchip_memory_dp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_onchip_memory_dp_pkg.sv
// Shared definitions for the LCD dual-port frame/text buffer: FSM encodings and collision priority.
package lcd_onchip_memory_dp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // On a same-address, same-cycle write from both slaves, s1 goes first and s2 is stalled a cycle.
    localparam bit COLLISION_S1_WINS = 1'b1;

endpackage

// File: rtl/lcd_mem_tdp_ram.sv
// True dual-port RAM with byte-lane writes; a read returns the word as it was before any same-edge write.
// Read data registers update only on a read strobe, so they hold the last value read.
module lcd_mem_tdp_ram #(
    parameter int DW = 32,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_re_i,
    input  logic [DW/8-1:0] a_we_i,
    input  logic [AW-1:0]   a_addr_i,
    input  logic [DW-1:0]   a_wdata_i,
    output logic [DW-1:0]   a_rdata_o,
    input  logic            b_re_i,
    input  logic [DW/8-1:0] b_we_i,
    input  logic [AW-1:0]   b_addr_i,
    input  logic [DW-1:0]   b_wdata_i,
    output logic [DW-1:0]   b_rdata_o
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_we_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            if (b_we_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
            if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/lcd_onchip_memory_dp.sv
// Dual Avalon-MM slave RAM for the LCD subsystem: clear-on-reset FSM, write-collision stall, read pipeline.
// Read latency 1 (OUTPUT_REG=0) or 2; clken low freezes everything and masks readdatavalid until it returns.
module lcd_onchip_memory_dp
    import lcd_onchip_memory_dp_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    OUTPUT_REG     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                  clr_we;
    logic                  ready;
    logic                  wr_coll;
    logic                  s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
    logic [1:0]            rv1_q;
    logic [NB-1:0]         a_we, b_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    assign ready   = (state_q == ST_READY) && clken;
    assign wr_coll = ready && s1_chipselect && s1_write && s2_chipselect && s2_write
                     && (s1_address == s2_address);

    assign s1_waitrequest = !ready || (wr_coll && !COLLISION_S1_WINS);
    assign s2_waitrequest = !ready || (wr_coll && COLLISION_S1_WINS);

    // A write on the same port wins over a simultaneous read and suppresses its readdatavalid.
    assign s1_wr_acc = !s1_waitrequest && s1_chipselect && s1_write;
    assign s1_rd_acc = !s1_waitrequest && s1_chipselect && s1_read && !s1_write;
    assign s2_wr_acc = !s2_waitrequest && s2_chipselect && s2_write;
    assign s2_rd_acc = !s2_waitrequest && s2_chipselect && s2_read && !s2_write;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clken) begin
                    if (CLEAR_ON_RESET == 0) begin
                        state_d = ST_READY;
                    end else begin
                        clr_we    = 1'b1;
                        clr_cnt_d = clr_cnt_q + 1'b1;
                        if (clr_cnt_d[ADDR_WIDTH]) state_d = ST_READY;
                    end
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rv1_q     <= '0;
        end else if (clken) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rv1_q     <= {s2_rd_acc, s1_rd_acc};
        end
    end

    assign init_done = (state_q == ST_READY);

    assign a_we    = clr_we ? {NB{1'b1}} : (s1_wr_acc ? s1_byteenable : '0);
    assign a_addr  = clr_we ? clr_cnt_q[ADDR_WIDTH-1:0] : s1_address;
    assign a_wdata = clr_we ? CLEAR_VALUE : s1_writedata;
    assign b_we    = s2_wr_acc ? s2_byteenable : '0;

    lcd_mem_tdp_ram #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_re_i    (s1_rd_acc),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_wdata_i (a_wdata),
        .a_rdata_o (a_rdata),
        .b_re_i    (s2_rd_acc),
        .b_we_i    (b_we),
        .b_addr_i  (s2_address),
        .b_wdata_i (s2_writedata),
        .b_rdata_o (b_rdata)
    );

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [1:0]            rv2_q;
            logic [DATA_WIDTH-1:0] out1_q, out2_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rv2_q  <= '0;
                    out1_q <= '0;
                    out2_q <= '0;
                end else if (clken) begin
                    rv2_q <= rv1_q;
                    if (rv1_q[0]) out1_q <= a_rdata;
                    if (rv1_q[1]) out2_q <= b_rdata;
                end
            end

            assign s1_readdata      = out1_q;
            assign s2_readdata      = out2_q;
            assign s1_readdatavalid = rv2_q[0] && clken;
            assign s2_readdatavalid = rv2_q[1] && clken;
        end else begin : g_noreg
            assign s1_readdata      = a_rdata;
            assign s2_readdata      = b_rdata;
            assign s1_readdatavalid = rv1_q[0] && clken;
            assign s2_readdatavalid = rv1_q[1] && clken;
        end
    endgenerate

endmodule

// File: tb/tb_lcd_onchip_memory_dp.sv
// Scoreboard bench for lcd_onchip_memory_dp (ADDR_WIDTH=4, OUTPUT_REG=0, clear-on-reset enabled).
module tb_lcd_onchip_memory_dp;

    localparam int OREG = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [3:0]  s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic        s1_waitrequest, s2_waitrequest;
    logic        init_done;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   lat_extra = 0;
    exp_t q1[$];
    exp_t q2[$];

    lcd_onchip_memory_dp #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (4),
        .OUTPUT_REG     (OREG),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (32'h0)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clken            (clken),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_waitrequest   (s1_waitrequest),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .s2_waitrequest   (s2_waitrequest),
        .init_done        (init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid beat must match the oldest outstanding expectation in data and cycle.
    exp_t m1, m2;
    always @(negedge clk) begin
        if (s1_readdatavalid) begin
            if (q1.size() == 0) begin
                tests++; failed++;
                $display("FAIL s1_unexpected_valid: data %h at cycle %0d", s1_readdata, cyc);
            end else begin
                m1 = q1.pop_front();
                chk("s1_rdata", s1_readdata, m1.d);
                chk("s1_valid_cycle", cyc, m1.c);
            end
        end
        if (s2_readdatavalid) begin
            if (q2.size() == 0) begin
                tests++; failed++;
                $display("FAIL s2_unexpected_valid: data %h at cycle %0d", s2_readdata, cyc);
            end else begin
                m2 = q2.pop_front();
                chk("s2_rdata", s2_readdata, m2.d);
                chk("s2_valid_cycle", cyc, m2.c);
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge that accepted the last request.
    task automatic op(input logic c1, input logic r1, input logic w1, input logic [3:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1, input logic [31:0] e1,
                      input logic c2, input logic r2, input logic w2, input logic [3:0] a2,
                      input logic [3:0] be2, input logic [31:0] d2, input logic [31:0] e2,
                      output int st1, output int st2);
        bit p1, p2;
        int n;
        exp_t e;
        p1 = c1; p2 = c2; st1 = 0; st2 = 0; n = 0;
        s1_chipselect = c1; s1_read = r1; s1_write = w1; s1_address = a1;
        s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = c2; s2_read = r2; s2_write = w2; s2_address = a2;
        s2_byteenable = be2; s2_writedata = d2;
        while ((p1 || p2) && n < 50) begin
            @(negedge clk);
            if (p1) begin
                if (!s1_waitrequest) begin
                    p1 = 0;
                    if (r1 && !w1) begin e.d = e1; e.c = cyc + 1 + OREG + lat_extra; q1.push_back(e); end
                end else st1++;
            end
            if (p2) begin
                if (!s2_waitrequest) begin
                    p2 = 0;
                    if (r2 && !w2) begin e.d = e2; e.c = cyc + 1 + OREG + lat_extra; q2.push_back(e); end
                end else st2++;
            end
            @(posedge clk); #1;
            if (!p1) begin s1_chipselect = 0; s1_read = 0; s1_write = 0; end
            if (!p2) begin s2_chipselect = 0; s2_read = 0; s2_write = 0; end
            n++;
        end
        if (p1 || p2) begin
            tests++; failed++;
            $display("FAIL op_timeout: pending s1=%0d s2=%0d expected 0 0", p1, p2);
            s1_chipselect = 0; s2_chipselect = 0;
        end
    endtask

    task automatic wr1(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        int s, t;
        op(1, 0, 1, a, be, d, 0, 0, 0, 0, 0, 0, 0, 0, s, t);
    endtask
    task automatic rd1(input logic [3:0] a, input logic [31:0] e);
        int s, t;
        op(1, 1, 0, a, 0, 0, e, 0, 0, 0, 0, 0, 0, 0, s, t);
    endtask
    task automatic wr2(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        int s, t;
        op(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, a, be, d, 0, s, t);
    endtask
    task automatic rd2(input logic [3:0] a, input logic [31:0] e);
        int s, t;
        op(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, a, 0, 0, e, s, t);
    endtask

    // Counts enabled cycles with waitrequest high, starting from the cycle reset is released.
    task automatic wait_clear(output int n);
        n = 0;
        @(negedge clk);
        while (s1_waitrequest && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s1_rdata"}, s1_readdata, 0);
        chk({tag, "_s2_rdata"}, s2_readdata, 0);
        chk({tag, "_s1_valid"}, s1_readdatavalid, 0);
        chk({tag, "_s2_valid"}, s2_readdatavalid, 0);
        chk({tag, "_s1_wait"}, s1_waitrequest, 1);
        chk({tag, "_s2_wait"}, s2_waitrequest, 1);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, t;
        reset_n = 0; clken = 1;
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = 0; s1_byteenable = 0; s1_writedata = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = 0; s2_byteenable = 0; s2_writedata = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");

        // Clear engine: 16 stalled cycles, then init_done and all-zero contents.
        @(posedge clk); #1; reset_n = 1;
        wait_clear(n);
        chk("clear_cycles", n, 16);
        chk("init_done", init_done, 1);
        chk("s2_wait_ready", s2_waitrequest, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rd1(i[3:0], 32'h0);

        // Write then read back; consecutive reads give one valid per cycle.
        wr1(5, 4'hF, 32'hDEADBEEF);
        rd1(5, 32'hDEADBEEF);
        rd1(5, 32'hDEADBEEF);

        // Byte-lane write on s2.
        wr2(3, 4'hF, 32'hAAAAAAAA);
        wr2(3, 4'b0101, 32'h11223344);
        rd2(3, 32'hAA22AA44);

        // Same-address write collision: s2 stalls one cycle, its data lands last.
        op(1, 0, 1, 7, 4'hF, 32'h1, 0, 1, 0, 1, 7, 4'hF, 32'h2, 0, s, t);
        chk("coll_s1_stall", s, 0);
        chk("coll_s2_stall", t, 1);
        rd1(7, 32'h2);
        op(1, 1, 0, 7, 0, 0, 32'h2, 1, 0, 1, 7, 4'hF, 32'h3, 0, s, t);
        chk("rbw_s2_stall", t, 0);
        rd1(7, 32'h3);
        op(1, 1, 0, 7, 0, 0, 32'h3, 1, 1, 0, 7, 0, 0, 32'h3, s, t);
        chk("dual_read_stall", s + t, 0);

        // Different-address writes from both ports in one cycle, read back crosswise.
        op(1, 0, 1, 9, 4'hF, 32'h99, 0, 1, 0, 1, 10, 4'hF, 32'h1010, 0, s, t);
        chk("diff_addr_stall", s + t, 0);
        rd1(10, 32'h1010);
        rd2(9, 32'h99);

        // Read+write on one port: write only. Zero byteenable write is a no-op.
        op(1, 1, 1, 8, 4'hF, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, s, t);
        rd1(8, 32'h55);
        wr1(8, 4'h0, 32'hFFFFFFFF);
        rd1(8, 32'h55);

        // clken low for 3 cycles with a read in flight.
        lat_extra = 3;
        rd1(5, 32'hDEADBEEF);
        lat_extra = 0;
        clken = 0;
        s2_chipselect = 1; s2_read = 1; s2_address = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clken_s1_wait", s1_waitrequest, 1);
            chk("clken_s2_wait", s2_waitrequest, 1);
            chk("clken_s1_valid", s1_readdatavalid, 0);
            @(posedge clk); #1;
        end
        clken = 1;
        s2_chipselect = 0; s2_read = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a clear restarts it from address 0.
        wr1(12, 4'hF, 32'hCAFEF00D);
        rd1(12, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1; reset_n = 0;
        @(posedge clk); #1; reset_n = 1;
        repeat (9) @(posedge clk);
        #1; reset_n = 0;
        #1;
        chk_reset_vals("midclr");
        @(posedge clk); #1; reset_n = 1;
        wait_clear(n);
        chk("reclear_cycles", n, 16);
        chk("reclear_init_done", init_done, 1);
        @(posedge clk); #1;
        rd1(12, 32'h0);
        rd2(5, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("s1_queue_drained", q1.size(), 0);
        chk("s2_queue_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
